// File: rtl/pad_ctrl_seq_pkg.sv
// Shared types and constants for the padframe controller.
package pad_ctrl_pkg;

    typedef struct packed {
        logic is;
        logic sr;
        logic ps;
        logic pe;
        logic ds1;
        logic ds0;
        logic ie;
        logic oe;
    } pad_cfg_t;

    typedef enum logic [1:0] {
        SAFE,
        SETTLE,
        INPUTS_ON,
        ACTIVE
    } seq_state_e;

    localparam pad_cfg_t PadCfgRst = 8'h02;

    function automatic int addr_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pad_ctrl_seq_if.sv
// Register access port of the pad controller: req/gnt with one-cycle read return.
interface pad_ctrl_seq_if #(
    parameter int AW = 3
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          gnt;
    logic          rvalid;
    logic [7:0]    rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/pad_ctrl_seq_in_filter.sv
// Per-pad receive path: two-flop synchroniser followed by a consecutive-sample deglitcher.
module pad_in_filter #(
    parameter int FilterDepth = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic y,
    input  logic ie,
    output logic data
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= y;
            sync_p1 <= sync_p0;
        end
    end

    if (FilterDepth == 0) begin : g_bypass
        assign data = sync_p1 & ie;
    end else begin : g_filt
        localparam int CntW = $clog2(FilterDepth + 1);

        logic [CntW-1:0] cnt;
        logic            data_q;

        // cnt counts consecutive cycles the synced value disagrees with the output
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt    <= '0;
                data_q <= 1'b0;
            end else if (!ie) begin
                cnt    <= '0;
                data_q <= 1'b0;
            end else if (sync_p1 == data_q) begin
                cnt <= '0;
            end else if (cnt == CntW'(FilterDepth - 1)) begin
                cnt    <= '0;
                data_q <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign data = data_q;
    end

endmodule

// File: rtl/pad_ctrl_seq.sv
// Core-side pad controller: per-pad config registers, power-up sequencer gating
// the pad drivers/receivers, registered pad controls and filtered receive data.
module pad_ctrl_seq
    import pad_ctrl_pkg::*;
#(
    parameter int NumPads      = 8,
    parameter int SettleCycles = 16,
    parameter int FilterDepth  = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    pad_ctrl_seq_if.slave      cfg,
    input  logic [NumPads-1:0] core_out_i,
    output logic [NumPads-1:0] core_in_o,
    output logic [NumPads-1:0] pad_a_o,
    output logic [NumPads-1:0] pad_oe_o,
    output logic [NumPads-1:0] pad_ie_o,
    output logic [NumPads-1:0] pad_ds0_o,
    output logic [NumPads-1:0] pad_ds1_o,
    output logic [NumPads-1:0] pad_pe_o,
    output logic [NumPads-1:0] pad_ps_o,
    output logic [NumPads-1:0] pad_sr_o,
    output logic [NumPads-1:0] pad_is_o,
    input  logic [NumPads-1:0] pad_y_i,
    output logic               seq_done_o
);

    localparam int AW = addr_w(NumPads);
    localparam int SW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [AW:0] NumPadsW = (AW + 1)'(NumPads);

    pad_cfg_t        cfg_q [NumPads];
    logic [AW-1:0]   addr;
    logic            in_range;
    logic            wr;
    logic            rd;

    seq_state_e      st, st_next;
    logic [SW-1:0]   cnt, cnt_next;
    logic            oe_en, ie_en, ctl_en;

    logic [NumPads-1:0] oe_d, ie_d, ds0_d, ds1_d, pe_d, ps_d, sr_d, is_d;

    assign addr     = cfg.addr;
    assign in_range = ({1'b0, addr} < NumPadsW);
    assign wr       = cfg.req & cfg.we & in_range;
    assign rd       = cfg.req & ~cfg.we;
    assign cfg.gnt  = cfg.req;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumPads; i++) cfg_q[i] <= PadCfgRst;
        end else if (wr) begin
            cfg_q[addr] <= pad_cfg_t'(cfg.wdata);
        end
    end

    // Out-of-range reads still complete, returning zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg.rvalid <= 1'b0;
            cfg.rdata  <= 8'h00;
        end else begin
            cfg.rvalid <= rd;
            if (rd) cfg.rdata <= in_range ? cfg_q[addr] : 8'h00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st  <= SAFE;
            cnt <= '0;
        end else begin
            st  <= st_next;
            cnt <= cnt_next;
        end
    end

    always_comb begin
        st_next  = st;
        cnt_next = cnt;
        oe_en    = 1'b0;
        ie_en    = 1'b0;
        ctl_en   = 1'b0;
        unique case (st)
            SAFE: begin
                st_next  = SETTLE;
                cnt_next = '0;
            end
            SETTLE: begin
                ctl_en = 1'b1;
                if (cnt == SW'(SettleCycles - 1)) begin
                    st_next  = INPUTS_ON;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            INPUTS_ON: begin
                ctl_en  = 1'b1;
                ie_en   = 1'b1;
                st_next = ACTIVE;
            end
            ACTIVE: begin
                ctl_en = 1'b1;
                ie_en  = 1'b1;
                oe_en  = 1'b1;
            end
            default: st_next = SAFE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NumPads; i++) begin
            oe_d[i]  = oe_en  & cfg_q[i].oe;
            ie_d[i]  = ie_en  & cfg_q[i].ie;
            ds0_d[i] = ctl_en & cfg_q[i].ds0;
            ds1_d[i] = ctl_en & cfg_q[i].ds1;
            pe_d[i]  = ctl_en & cfg_q[i].pe;
            ps_d[i]  = ctl_en & cfg_q[i].ps;
            sr_d[i]  = ctl_en & cfg_q[i].sr;
            is_d[i]  = ctl_en & cfg_q[i].is;
        end
    end

    // Pad control stage: everything the padframe sees is registered here
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_a_o   <= '0;
            pad_oe_o  <= '0;
            pad_ie_o  <= '0;
            pad_ds0_o <= '0;
            pad_ds1_o <= '0;
            pad_pe_o  <= '0;
            pad_ps_o  <= '0;
            pad_sr_o  <= '0;
            pad_is_o  <= '0;
        end else begin
            pad_a_o   <= core_out_i;
            pad_oe_o  <= oe_d;
            pad_ie_o  <= ie_d;
            pad_ds0_o <= ds0_d;
            pad_ds1_o <= ds1_d;
            pad_pe_o  <= pe_d;
            pad_ps_o  <= ps_d;
            pad_sr_o  <= sr_d;
            pad_is_o  <= is_d;
        end
    end

    assign seq_done_o = (st == ACTIVE);

    // Filters clear on the IE value being loaded so core_in_o drops with pad_ie_o
    for (genvar i = 0; i < NumPads; i++) begin : g_pad
        pad_in_filter #(
            .FilterDepth(FilterDepth)
        ) u_filt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .y      (pad_y_i[i]),
            .ie     (ie_d[i]),
            .data   (core_in_o[i])
        );
    end

endmodule

// File: tb/tb_pad_ctrl_seq.sv
// Bench for pad_ctrl_seq: directed power-up/config/filter/reset steps plus random traffic,
// all outputs compared every cycle with a cycle-count based behavioural model.
module tb_pad_ctrl_seq;
    import pad_ctrl_pkg::*;

    localparam int NP = 6;
    localparam int SC = 5;
    localparam int FD = 3;
    localparam int AW = addr_w(NP);

    logic clk = 1'b0;
    logic rst_n;
    logic [NP-1:0] core_out, core_in, pad_y;
    logic [NP-1:0] pad_a, pad_oe, pad_ie, pad_ds0, pad_ds1, pad_pe, pad_ps, pad_sr, pad_is;
    logic seq_done;
    logic [NP-1:0] ones = '1;

    int total = 0;
    int bad = 0;

    pad_ctrl_seq_if #(.AW(AW)) cfg_bus ();

    pad_ctrl_seq #(
        .NumPads(NP), .SettleCycles(SC), .FilterDepth(FD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg(cfg_bus),
        .core_out_i(core_out), .core_in_o(core_in),
        .pad_a_o(pad_a), .pad_oe_o(pad_oe), .pad_ie_o(pad_ie),
        .pad_ds0_o(pad_ds0), .pad_ds1_o(pad_ds1), .pad_pe_o(pad_pe),
        .pad_ps_o(pad_ps), .pad_sr_o(pad_sr), .pad_is_o(pad_is),
        .pad_y_i(pad_y), .seq_done_o(seq_done)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0]    m_cfg [NP];
    logic [NP-1:0] m_a, m_oe, m_ie, m_ds0, m_ds1, m_pe, m_ps, m_sr, m_is, m_in;
    logic          m_rvalid;
    logic [7:0]    m_rdata;
    logic [NP-1:0] yq [$];
    logic [NP-1:0] sq [$];
    int            ie_run [NP];
    int            ncyc;

    // Sequencer phase during cycle n after reset release: 0 SAFE, 1 SETTLE, 2 INPUTS_ON, 3 ACTIVE
    function automatic int phase(int n);
        if (n == 0) return 0;
        if (n <= SC) return 1;
        if (n == SC + 1) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_cfg[p]  = 8'h02;
            ie_run[p] = 0;
        end
        {m_a, m_oe, m_ie, m_ds0, m_ds1, m_pe, m_ps, m_sr, m_is, m_in} = '0;
        m_rvalid = 1'b0;
        m_rdata  = 8'h00;
        yq.delete();
        sq.delete();
        yq.push_back('0);
        yq.push_back('0);
        ncyc = 0;
    endtask

    task automatic model_edge();
        int ph;
        logic [7:0] c;
        logic [NP-1:0] sv;
        bit all_diff;
        ph = phase(ncyc);
        for (int p = 0; p < NP; p++) begin
            c = m_cfg[p];
            m_oe[p]  = (ph == 3) && c[0];
            m_ie[p]  = (ph >= 2) && c[1];
            m_ds0[p] = (ph >= 1) && c[2];
            m_ds1[p] = (ph >= 1) && c[3];
            m_pe[p]  = (ph >= 1) && c[4];
            m_ps[p]  = (ph >= 1) && c[5];
            m_sr[p]  = (ph >= 1) && c[6];
            m_is[p]  = (ph >= 1) && c[7];
        end
        m_a = core_out;
        m_rvalid = cfg_bus.req && !cfg_bus.we;
        if (m_rvalid) begin
            if (int'(cfg_bus.addr) < NP) m_rdata = m_cfg[cfg_bus.addr];
            else m_rdata = 8'h00;
        end
        if (cfg_bus.req && cfg_bus.we && int'(cfg_bus.addr) < NP) m_cfg[cfg_bus.addr] = cfg_bus.wdata;
        // receive path: value seen by the deglitcher is the pad sample from two edges earlier
        yq.push_back(pad_y);
        sv = yq[yq.size() - 3];
        sq.push_back(sv);
        for (int p = 0; p < NP; p++) begin
            if (!m_ie[p]) begin
                m_in[p]   = 1'b0;
                ie_run[p] = 0;
            end else begin
                ie_run[p]++;
                if (ie_run[p] >= FD) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < FD; k++)
                        if (sq[sq.size() - 1 - k][p] == m_in[p]) all_diff = 1'b0;
                    if (all_diff) m_in[p] = !m_in[p];
                end
            end
        end
        while (yq.size() > 4) void'(yq.pop_front());
        while (sq.size() > FD + 2) void'(sq.pop_front());
        ncyc++;
    endtask

    task automatic check_all(input string t);
        chk({t, ".a"},      pad_a,   m_a);
        chk({t, ".oe"},     pad_oe,  m_oe);
        chk({t, ".ie"},     pad_ie,  m_ie);
        chk({t, ".ds0"},    pad_ds0, m_ds0);
        chk({t, ".ds1"},    pad_ds1, m_ds1);
        chk({t, ".pe"},     pad_pe,  m_pe);
        chk({t, ".ps"},     pad_ps,  m_ps);
        chk({t, ".sr"},     pad_sr,  m_sr);
        chk({t, ".is"},     pad_is,  m_is);
        chk({t, ".core_in"}, core_in, m_in);
        chk({t, ".rvalid"}, cfg_bus.rvalid, m_rvalid);
        chk({t, ".rdata"},  cfg_bus.rdata,  m_rdata);
        chk({t, ".done"},   seq_done, phase(ncyc) == 3);
        chk({t, ".gnt"},    cfg_bus.gnt, cfg_bus.req);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic cfg_idle();
        cfg_bus.req   = 1'b0;
        cfg_bus.we    = 1'b0;
        cfg_bus.addr  = '0;
        cfg_bus.wdata = 8'h00;
    endtask

    task automatic cfg_wr(input int a, input logic [7:0] d);
        cfg_bus.req   = 1'b1;
        cfg_bus.we    = 1'b1;
        cfg_bus.addr  = AW'(a);
        cfg_bus.wdata = d;
        tick();
        cfg_idle();
    endtask

    task automatic cfg_rd(input int a);
        cfg_bus.req  = 1'b1;
        cfg_bus.we   = 1'b0;
        cfg_bus.addr = AW'(a);
        tick();
        cfg_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        core_out = '0;
        pad_y    = '0;
        cfg_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        #1;
        rst_n    = 1'b1;
        core_out = '1;

        // T1: power-up sequence
        for (int n = 1; n <= SC + 3; n++) begin
            tick();
            if (n <= SC + 1) chk("t1_oe_off", pad_oe, '0);
            chk("t1_ie", pad_ie, (n >= SC + 2) ? ones : '0);
            chk("t1_done", seq_done, n >= SC + 2);
            chk("t1_a", pad_a, ones);
        end

        // T2: write then read back pad 3
        cfg_wr(3, 8'h03);
        chk("t2_oe_early", pad_oe[3], 1'b0);
        tick();
        chk("t2_oe", pad_oe[3], 1'b1);
        cfg_rd(3);
        chk("t2_rvalid", cfg_bus.rvalid, 1'b1);
        chk("t2_rdata", cfg_bus.rdata, 8'h03);
        tick();
        chk("t2_rvalid_drop", cfg_bus.rvalid, 1'b0);
        chk("t2_rdata_hold", cfg_bus.rdata, 8'h03);

        // T4: out-of-range access
        cfg_wr(7, 8'hFF);
        tick();
        chk("t4_oe", pad_oe, 6'b001000);
        chk("t4_ie", pad_ie, ones);
        chk("t4_pe", pad_pe, '0);
        chk("t4_is", pad_is, '0);
        cfg_rd(7);
        chk("t4_rvalid", cfg_bus.rvalid, 1'b1);
        chk("t4_rdata", cfg_bus.rdata, 8'h00);

        // T3: 2-cycle glitch is rejected, 3-cycle pulse passes after 5 cycles
        for (int i = 0; i < 10; i++) begin
            pad_y[0] = (i < 2);
            tick();
            chk("t3_glitch", core_in[0], 1'b0);
        end
        for (int i = 1; i <= 10; i++) begin
            pad_y[0] = (i <= 3);
            tick();
            chk("t3_pulse", core_in[0], (i >= 5 && i <= 7));
        end

        // T6: clearing IE forces the core input low
        pad_y[2] = 1'b1;
        repeat (6) tick();
        chk("t6_pre", core_in[2], 1'b1);
        cfg_wr(2, 8'h00);
        chk("t6_mid", core_in[2], 1'b1);
        tick();
        chk("t6_core", core_in[2], 1'b0);
        chk("t6_ie", pad_ie[2], 1'b0);
        cfg_wr(2, 8'h02);
        repeat (7) tick();
        chk("t6_back", core_in[2], 1'b1);
        pad_y[2] = 1'b0;

        // T5: asynchronous reset while driving
        cfg_wr(0, 8'h03);
        tick();
        chk("t5_pre", pad_oe, 6'b001001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_oe", pad_oe, '0);
        chk("t5_ie", pad_ie, '0);
        chk("t5_done", seq_done, 1'b0);
        chk("t5_core", core_in, '0);
        chk("t5_rvalid", cfg_bus.rvalid, 1'b0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int a = 0; a < NP; a++) begin
            cfg_rd(a);
            chk("t5_cfg", cfg_bus.rdata, 8'h02);
        end

        // Random traffic against the model
        repeat (SC + 3) tick();
        for (int i = 0; i < 400; i++) begin
            cfg_bus.req   = 1'($urandom_range(0, 1));
            cfg_bus.we    = 1'($urandom_range(0, 1));
            cfg_bus.addr  = AW'($urandom_range(0, 7));
            cfg_bus.wdata = 8'($urandom);
            core_out      = NP'($urandom);
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 3) == 0) pad_y[p] = !pad_y[p];
            tick();
        end
        cfg_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
